// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: opcode map,
// destination-index layout, commit class and opcode decode.
package writeback_stage_pkg;

  localparam int REG_W  = 16;
  localparam int VREG_W = 64;
  localparam int OPC_W  = 8;

  localparam int DEST_VEC_BIT = 5;
  localparam int DEST_IDX_W   = 4;

  localparam logic [OPC_W-1:0] OP_NOP      = 8'h00;
  localparam logic [OPC_W-1:0] OP_ADD      = 8'h01;
  localparam logic [OPC_W-1:0] OP_SUB      = 8'h02;
  localparam logic [OPC_W-1:0] OP_AND      = 8'h03;
  localparam logic [OPC_W-1:0] OP_OR       = 8'h04;
  localparam logic [OPC_W-1:0] OP_XOR      = 8'h05;
  localparam logic [OPC_W-1:0] OP_ADDI     = 8'h06;
  localparam logic [OPC_W-1:0] OP_ANDI     = 8'h07;
  localparam logic [OPC_W-1:0] OP_MOV      = 8'h08;
  localparam logic [OPC_W-1:0] OP_MOVI     = 8'h09;
  localparam logic [OPC_W-1:0] OP_LDW      = 8'h10;
  localparam logic [OPC_W-1:0] OP_STW      = 8'h11;
  localparam logic [OPC_W-1:0] OP_BRN      = 8'h20;
  localparam logic [OPC_W-1:0] OP_BRZ      = 8'h21;
  localparam logic [OPC_W-1:0] OP_BRP      = 8'h22;
  localparam logic [OPC_W-1:0] OP_BRNZ     = 8'h23;
  localparam logic [OPC_W-1:0] OP_BRNP     = 8'h24;
  localparam logic [OPC_W-1:0] OP_BRZP     = 8'h25;
  localparam logic [OPC_W-1:0] OP_BRNZP    = 8'h26;
  localparam logic [OPC_W-1:0] OP_JMP      = 8'h28;
  localparam logic [OPC_W-1:0] OP_JSR      = 8'h2A;
  localparam logic [OPC_W-1:0] OP_JSRR     = 8'h2B;
  localparam logic [OPC_W-1:0] OP_VADD     = 8'h30;
  localparam logic [OPC_W-1:0] OP_VSUB     = 8'h31;
  localparam logic [OPC_W-1:0] OP_VMOV     = 8'h32;
  localparam logic [OPC_W-1:0] OP_VMOVI    = 8'h33;
  localparam logic [OPC_W-1:0] OP_VCOMPMOV = 8'h34;

  typedef enum logic [1:0] {
    WB_NONE   = 2'd0,
    WB_SCALAR = 2'd1,
    WB_VECTOR = 2'd2
  } wb_class_e;

  function automatic logic is_scalar_wb(
    input logic [OPC_W-1:0] op
  );
    logic r;
    r = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_ADDI, OP_ANDI, OP_MOV,
      OP_MOVI, OP_LDW, OP_JSR, OP_JSRR:
        r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_vector_wb(
    input logic [OPC_W-1:0] op
  );
    logic r;
    r = 1'b0;
    case (op)
      OP_VADD, OP_VSUB, OP_VMOV,
      OP_VMOVI, OP_VCOMPMOV:
        r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Stores, branches, jumps, NOP and unknown opcodes retire silently.
  function automatic wb_class_e wb_class(
    input logic [OPC_W-1:0] op
  );
    wb_class_e c;
    c = WB_NONE;
    unique case (1'b1)
      is_scalar_wb(op): c = WB_SCALAR;
      is_vector_wb(op): c = WB_VECTOR;
      default:          c = WB_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/writeback_stage_commit_fifo.sv
// In-order commit buffer: circular store with head/tail pointers,
// negedge-clocked to match the rest of the stage.
module wb_commit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A full buffer accepts only when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[head];

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop_ok)  head <= head + 1'b1;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
    end
  end

  always_ff @(negedge clk) begin
    if (push_ok) mem[tail] <= wdata;
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: classifies, buffers and commits results to
// the scalar/vector register files, releases scoreboard entries.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int REG_WIDTH    = REG_W,
  parameter int VREG_WIDTH   = VREG_W,
  parameter int OPCODE_WIDTH = OPC_W,
  parameter int BUF_DEPTH    = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET_N,
  input  logic                    I_LOCK,
  input  logic                    I_FetchStall,
  input  logic                    I_DepStall,
  input  logic                    I_FRAMESTALL,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [5:0]              I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]    I_ALUOut,
  input  logic [REG_WIDTH-1:0]    I_MemOut,
  input  logic [VREG_WIDTH-1:0]   I_VALUOut,
  output logic                    O_WriteEn,
  output logic [3:0]              O_WriteIdx,
  output logic [REG_WIDTH-1:0]    O_WriteData,
  output logic                    O_VWriteEn,
  output logic [3:0]              O_VWriteIdx,
  output logic [VREG_WIDTH-1:0]   O_VWriteData,
  output logic                    O_ReleaseEn,
  output logic [5:0]              O_ReleaseIdx,
  output logic                    O_WBFull,
  output logic                    O_Overflow,
  output logic [CNT_WIDTH-1:0]    O_RetireCount
);

  typedef struct packed {
    wb_class_e              cls;
    logic [5:0]             idx;
    logic [REG_WIDTH-1:0]   sdata;
    logic [VREG_WIDTH-1:0]  vdata;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t in_e;
  entry_t head_e;
  entry_t out_e;

  logic accept;
  logic bypass;
  logic push;
  logic pop;
  logic drain;
  logic empty;
  logic full;
  logic drop;

  always_comb begin
    in_e       = '0;
    in_e.cls   = wb_class(I_Opcode);
    in_e.idx   = I_DestRegIdx;
    in_e.sdata = (I_Opcode == OP_LDW) ? I_MemOut : I_ALUOut;
    in_e.vdata = I_VALUOut;
  end

  assign accept = I_LOCK && !I_FetchStall && !I_DepStall;
  assign pop    = !empty && !I_FRAMESTALL;
  assign bypass = empty && accept && !I_FRAMESTALL;
  assign push   = accept && !bypass;
  assign drain  = pop || bypass;
  assign out_e  = empty ? in_e : head_e;
  // Entry lost only when nothing leaves to make room.
  assign drop   = push && full && !pop;

  wb_commit_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (I_CLOCK),
    .rst_n (I_RESET_N),
    .push  (push),
    .pop   (pop),
    .wdata (in_e),
    .rdata (head_e),
    .full  (full),
    .empty (empty)
  );

  assign O_WBFull = full;

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      O_WriteEn     <= 1'b0;
      O_WriteIdx    <= '0;
      O_WriteData   <= '0;
      O_VWriteEn    <= 1'b0;
      O_VWriteIdx   <= '0;
      O_VWriteData  <= '0;
      O_ReleaseEn   <= 1'b0;
      O_ReleaseIdx  <= '0;
      O_Overflow    <= 1'b0;
      O_RetireCount <= '0;
    end else begin
      O_WriteEn   <= 1'b0;
      O_VWriteEn  <= 1'b0;
      O_ReleaseEn <= 1'b0;
      if (drop) O_Overflow <= 1'b1;
      if (drain) begin
        O_RetireCount <= O_RetireCount + 1'b1;
        case (out_e.cls)
          WB_SCALAR: begin
            O_WriteEn    <= 1'b1;
            O_WriteIdx   <= out_e.idx[3:0];
            O_WriteData  <= out_e.sdata;
            O_ReleaseEn  <= 1'b1;
            O_ReleaseIdx <= out_e.idx;
          end
          WB_VECTOR: begin
            O_VWriteEn   <= 1'b1;
            O_VWriteIdx  <= out_e.idx[3:0];
            O_VWriteData <= out_e.vdata;
            O_ReleaseEn  <= 1'b1;
            O_ReleaseIdx <= out_e.idx;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Consumes the memory stage's outputs (ALU/vector result, load data, opcode, destination index, stall tags).
- Commits results to the scalar and vector register files in decode and releases the decode scoreboard entry.
- Holds a small in-order commit buffer so that writes arriving while I_FRAMESTALL blocks the register-file port are not lost.
- Keeps a retired-instruction counter.

Parameters:
- REG_WIDTH, 16, scalar data width
- VREG_WIDTH, 64, vector data width (4 x 16-bit lanes)
- OPCODE_WIDTH, 8, opcode width
- BUF_DEPTH, 2, commit buffer entries (power of two, >=2)
- CNT_WIDTH, 32, retire counter width

Ports:
- I_CLOCK  in  1  pipeline clock; stage state updates on negedge, matching upstream stages
- I_RESET_N  in  1  asynchronous active-low reset
- I_LOCK  in  1  upstream valid/lock
- I_FetchStall  in  1  bubble tag from upstream
- I_DepStall  in  1  bubble tag from upstream
- I_FRAMESTALL  in  1  register-file port blocked by frame/GPU access
- I_Opcode  in  OPCODE_WIDTH  opcode
- I_DestRegIdx  in  6  bit5=1 vector reg, [3:0] register index
- I_ALUOut  in  REG_WIDTH  scalar ALU result or link PC
- I_MemOut  in  REG_WIDTH  load data
- I_VALUOut  in  VREG_WIDTH  vector result
- O_WriteEn  out  1  scalar regfile write strobe
- O_WriteIdx  out  4  scalar write index
- O_WriteData  out  REG_WIDTH  scalar write data
- O_VWriteEn  out  1  vector regfile write strobe
- O_VWriteIdx  out  4  vector write index
- O_VWriteData  out  VREG_WIDTH  vector write data
- O_ReleaseEn  out  1  scoreboard release pulse to decode
- O_ReleaseIdx  out  6  register index being released
- O_WBFull  out  1  commit buffer full
- O_Overflow  out  1  sticky error flag: dropped commit
- O_RetireCount  out  CNT_WIDTH  retired instruction count

Behaviour:
- Reset (async, I_RESET_N=0): all outputs 0, buffer empty, count 0. Reset mid-drain discards buffered entries.
- Accept condition, sampled at negedge: I_LOCK && !I_FetchStall && !I_DepStall.
- Each accepted instruction forms an entry {class, idx, sdata, vdata}.
- Class:
  - SCALAR for scalar ALU ops, OP_LDW, OP_JSR, OP_JSRR.
  - VECTOR for vector ops.
  - NONE for OP_STW, branches, OP_JMP, NOP.
- Scalar data: I_MemOut if OP_LDW, else I_ALUOut. JSR/JSRR write R7 via I_DestRegIdx supplied upstream.
- Drain condition: !I_FRAMESTALL and an entry exists (buffered or bypass).
- Bypass: buffer empty, accept, and !I_FRAMESTALL.
  - Entry drives the write outputs on the same negedge; latency 1 edge from the memory stage output.
- Otherwise the accepted entry enqueues at the tail. The oldest entry drains one per edge; order is strictly preserved.
  - No bypass around a non-empty buffer.
- On a drained entry:
  - SCALAR: O_WriteEn=1, O_WriteIdx=idx[3:0], O_WriteData=sdata.
  - VECTOR: O_VWriteEn=1, O_VWriteIdx, O_VWriteData.
  - NONE: no strobe.
  - All classes: O_RetireCount += 1, wrapping modulo 2^CNT_WIDTH.
  - SCALAR/VECTOR also pulse O_ReleaseEn with O_ReleaseIdx=idx.
- All strobes are single-edge pulses. On non-drain edges the strobes are 0 and the data/index outputs hold their last values.
- O_WBFull = (count==BUF_DEPTH). It is registered and updated on the same edge as count.
- Full with simultaneous accept and drain: both happen, count unchanged, no overflow.
- Full with accept and no drain: the entry is dropped, O_Overflow sets and stays set until reset, count unchanged.
- I_FRAMESTALL asserted: no strobes, no retire increments, accepts still enqueue.
- I_FRAMESTALL deasserting: drain resumes on the next negedge where it is sampled low.

Decomposition:
- Opcode encodings, REG/VREG/OPCODE widths and the DestRegIdx field layout (vector bit 5, index [3:0]) live in the shared global_def.h header.
- Class encoding (NONE/SCALAR/VECTOR) and the is_scalar_wb/is_vector_wb opcode decode are added to that header.
- One sub-module, wb_commit_fifo:
  - parameterised width/depth circular buffer with head/tail pointers and count
  - push/pop/full/empty ports
  - async active-low reset
- Top level holds classification, bypass mux, strobes and counter.

Test Plan:
- Reset: hold I_RESET_N=0 with I_LOCK=1 and traffic present -> all outputs 0; release -> first accepted ADD, idx 3, ALUOut 0x0042 gives O_WriteEn=1, idx 3, data 0x0042, O_ReleaseIdx=3, count 1.
- Load select: OP_LDW, idx 5, ALUOut 0x0010, MemOut 0xBEEF -> O_WriteData=0xBEEF. OP_STW -> no strobe, count increments, no release.
- Vector: vector op, DestRegIdx 6'b100010, VALUOut 0x0001_0002_0003_0004 -> O_VWriteEn=1, idx 2, that data, O_ReleaseIdx=0x22, O_WriteEn=0.
- Frame stall: FRAMESTALL=1, accept ADD r1=0x11 then ADD r2=0x22 -> no strobes, O_WBFull=1; drop FRAMESTALL -> r1 commits on edge N, r2 on edge N+1, WBFull clears.
- Overflow: buffer full, FRAMESTALL=1, third accept -> dropped, O_Overflow=1 sticky; full with FRAMESTALL=0 and accept -> no overflow, count stays 2.
- Bubbles and wrap: I_DepStall=1 or I_FetchStall=1 -> nothing enqueued or retired; preload count near 2^CNT_WIDTH-1 (force or small CNT_WIDTH=4) -> 15 then 0.
